decimal_keypad_to_bcd: RTL and testbench



---
 rtl/decimal_keypad_to_bcd_pkg.sv | 40 ++++
 rtl/decimal_keypad_to_bcd_if.sv | 37 +++
 rtl/decimal_keypad_to_bcd_onehot10_to_bcd.sv | 19 +
 rtl/decimal_keypad_to_bcd.sv | 177 +++++++++++++++++
 tb/tb_decimal_keypad_to_bcd.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/decimal_keypad_to_bcd_pkg.sv
// Shared types and helpers for the decimal keypad to BCD encoder.
// The optional DECKEY_STICKY_ERR_EN build only affects the top module.
package deckey_pkg;

   localparam int BCD_W = 4;
   localparam int DEC_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      PRESS,
      HELD,
      RELEASE,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_ONEHOT,
      CLS_MULTI
   } class_t;

   function automatic logic is_zero(input logic [DEC_W-1:0] v);
      return (v == '0);
   endfunction

   // Clearing the lowest set bit leaves zero only when a single bit was set.
   function automatic logic is_onehot(input logic [DEC_W-1:0] v);
      return (v != '0) && ((v & (v - DEC_W'(1))) == '0);
   endfunction

   function automatic class_t classify(input logic [DEC_W-1:0] v);
      if (is_zero(v))
         return CLS_ZERO;
      else if (is_onehot(v))
         return CLS_ONEHOT;
      else
         return CLS_MULTI;
   endfunction

endpackage

// File: rtl/decimal_keypad_to_bcd_if.sv
// Keypad-side and accumulator-side signals of the decimal keypad encoder.
// The master modport is the keypad/consumer side, slave is the encoder.
interface decimal_keypad_to_bcd_if
   import deckey_pkg::*;
#(
   parameter int DIGITS = 4
);

   logic [DEC_W-1:0]            DECIn;
   logic                        Clear;
   logic [BCD_W-1:0]            DigitOut;
   logic                        DigitValid;
   logic [BCD_W*DIGITS-1:0]     Accum;
   logic [$clog2(DIGITS+1)-1:0] DigitCount;
   logic                        Err;

   modport master (
      output DECIn,
      output Clear,
      input  DigitOut,
      input  DigitValid,
      input  Accum,
      input  DigitCount,
      input  Err
   );

   modport slave (
      input  DECIn,
      input  Clear,
      output DigitOut,
      output DigitValid,
      output Accum,
      output DigitCount,
      output Err
   );

endinterface

// File: rtl/decimal_keypad_to_bcd_onehot10_to_bcd.sv
// Combinational 10-line one-hot to BCD encoder; o_valid flags a legal one-hot code.
module onehot10_to_bcd
   import deckey_pkg::*;
(
   input  logic [DEC_W-1:0] i_onehot,
   output logic [BCD_W-1:0] o_bcd,
   output logic             o_valid
);

   always_comb begin
      o_bcd = '0;
      for (int n = 0; n < DEC_W; n++) begin
         if (i_onehot[n])
            o_bcd = BCD_W'(n);
      end
      o_valid = is_onehot(i_onehot);
   end

endmodule

// File: rtl/decimal_keypad_to_bcd.sv
// Synchronises, debounces and validates a one-hot decimal keypad and shifts digits into a BCD accumulator.
// Define DECKEY_STICKY_ERR_EN to make Err hold until Clear instead of pulsing.
module decimal_keypad_to_bcd
   import deckey_pkg::*;
#(
   parameter int DEBOUNCE = 4,
   parameter int DIGITS   = 4
)
(
   input logic                    Clk,
   input logic                    Reset,
   decimal_keypad_to_bcd_if.slave bus
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam int DC_W  = $clog2(DIGITS + 1);
   localparam int ACC_W = BCD_W * DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DC_W-1:0]  DC_MAX   = DC_W'(DIGITS);

   logic [DEC_W-1:0] r_sync1;
   logic [DEC_W-1:0] r_sync2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [DEC_W-1:0] r_cand;
   logic [BCD_W-1:0] r_digitOut;
   logic             r_digitValid;
   logic [ACC_W-1:0] r_accum;
   logic [DC_W-1:0]  r_digitCount;
   logic             r_err;

   state_t           w_stateNext;
   logic [CNT_W-1:0] w_cntNext;
   logic [DEC_W-1:0] w_candNext;
   logic             w_accept;
   logic             w_errEntry;
   class_t           w_cls;
   logic [BCD_W-1:0] w_bcd;
   logic             w_bcdValid;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.DECIn;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_cand  <= w_candNext;
      end
   end

   // Leaving ERR or HELD on a zero sample already counts as the first release sample.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_candNext  = r_cand;
      w_accept    = 1'b0;
      w_errEntry  = 1'b0;
      w_cls       = classify(r_sync2);
      case (r_state)
         IDLE: begin
            if (w_cls == CLS_ONEHOT) begin
               w_candNext = r_sync2;
               w_cntNext  = CNT_ONE;
               if (DEBOUNCE == 1) begin
                  w_accept    = 1'b1;
                  w_stateNext = HELD;
               end else begin
                  w_stateNext = PRESS;
               end
            end else if (w_cls == CLS_MULTI) begin
               w_errEntry  = 1'b1;
               w_stateNext = ERR;
            end
         end
         PRESS: begin
            if (w_cls == CLS_MULTI) begin
               w_errEntry  = 1'b1;
               w_stateNext = ERR;
            end else if (w_cls == CLS_ZERO) begin
               w_cntNext   = '0;
               w_stateNext = IDLE;
            end else if (r_sync2 == r_cand) begin
               w_cntNext = r_cnt + CNT_ONE;
               if (r_cnt == CNT_LAST) begin
                  w_accept    = 1'b1;
                  w_stateNext = HELD;
               end
            end else begin
               w_candNext = r_sync2;
               w_cntNext  = CNT_ONE;
            end
         end
         HELD, ERR: begin
            if (w_cls == CLS_ZERO) begin
               w_cntNext   = CNT_ONE;
               w_stateNext = (DEBOUNCE == 1) ? IDLE : RELEASE;
            end
         end
         RELEASE: begin
            if (w_cls != CLS_ZERO) begin
               w_stateNext = HELD;
            end else if (r_cnt == CNT_LAST) begin
               w_cntNext   = '0;
               w_stateNext = IDLE;
            end else begin
               w_cntNext = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Fed from the candidate's next value so a DEBOUNCE=1 accept from IDLE sees the new key.
   onehot10_to_bcd u_encoder (
      .i_onehot (w_candNext),
      .o_bcd    (w_bcd),
      .o_valid  (w_bcdValid)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_digitOut   <= '0;
         r_digitValid <= 1'b0;
         r_accum      <= '0;
         r_digitCount <= '0;
      end else begin
         r_digitValid <= w_accept && w_bcdValid;
         if (w_accept && w_bcdValid)
            r_digitOut <= w_bcd;
         if (bus.Clear) begin
            r_accum      <= '0;
            r_digitCount <= '0;
         end else if (w_accept && w_bcdValid) begin
            r_accum <= (r_accum << BCD_W) | ACC_W'(w_bcd);
            if (r_digitCount != DC_MAX)
               r_digitCount <= r_digitCount + DC_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_err <= 1'b0;
      end else begin
`ifdef DECKEY_STICKY_ERR_EN
         if (bus.Clear)
            r_err <= 1'b0;
         else if (w_errEntry)
            r_err <= 1'b1;
`else
         r_err <= w_errEntry;
`endif
      end
   end

   assign bus.DigitOut   = r_digitOut;
   assign bus.DigitValid = r_digitValid;
   assign bus.Accum      = r_accum;
   assign bus.DigitCount = r_digitCount;
   assign bus.Err        = r_err;

endmodule

// File: tb/tb_decimal_keypad_to_bcd.sv
// Self-checking bench for decimal_keypad_to_bcd: directed and randomized key presses
// checked against a digit-queue model of the accumulator.
module tb_decimal_keypad_to_bcd;

   localparam int DEBOUNCE = 4;
   localparam int DIGITS   = 4;

   logic Clk;
   logic Reset;

   int checks     = 0;
   int failures   = 0;
   int pulseCount = 0;
   int errCount   = 0;
   logic [3:0] lastDigit = '0;

   int modelDigits[$];
   int entered = 0;

   decimal_keypad_to_bcd_if #(.DIGITS(DIGITS)) bus ();

   decimal_keypad_to_bcd #(
      .DEBOUNCE (DEBOUNCE),
      .DIGITS   (DIGITS)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Counts output pulses shortly after each rising edge.
   always @(posedge Clk) begin
      #1;
      if (bus.DigitValid) begin
         pulseCount++;
         lastDigit = bus.DigitOut;
      end
      if (bus.Err)
         errCount++;
   end

   function automatic void pushDigit(input int d);
      modelDigits.push_back(d);
      entered++;
   endfunction

   function automatic void modelClear();
      modelDigits.delete();
      entered = 0;
   endfunction

   // Accumulator value is the last DIGITS entered digits read as a base-16 number.
   function automatic logic [31:0] modelAccum();
      logic [31:0] v;
      int first;
      v = 0;
      first = (modelDigits.size() > DIGITS) ? modelDigits.size() - DIGITS : 0;
      for (int i = first; i < modelDigits.size(); i++)
         v = v * 16 + modelDigits[i];
      return v;
   endfunction

   function automatic logic [31:0] modelCount();
      return (entered > DIGITS) ? DIGITS : entered;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] lines, input int cycles);
      bus.DECIn = lines;
      repeat (cycles) @(negedge Clk);
   endtask

   task automatic clearAccum();
      bus.Clear = 1'b1;
      @(negedge Clk);
      bus.Clear = 1'b0;
      modelClear();
   endtask

   task automatic pressDigit(input int d, input int hold);
      int p0;
      int lat;
      logic [9:0] key;
      key = 10'b1 << d;
      p0  = pulseCount;
      lat = -1;
      bus.DECIn = key;
      for (int k = 1; k <= hold; k++) begin
         @(negedge Clk);
         if (lat < 0 && pulseCount != p0)
            lat = k;
      end
      pushDigit(d);
      checkOutput($sformatf("latency_d%0d", d), lat, DEBOUNCE + 2);
      checkOutput($sformatf("pulses_d%0d", d), pulseCount - p0, 1);
      checkOutput($sformatf("digitout_d%0d", d), bus.DigitOut, d);
      checkOutput($sformatf("accum_d%0d", d), bus.Accum, modelAccum());
      checkOutput($sformatf("count_d%0d", d), bus.DigitCount, modelCount());
      applyStimulus('0, 12);
   endtask

   initial begin
      int p0;
      int e0;
      bus.DECIn = '0;
      bus.Clear = 1'b0;
      Reset     = 1'b1;
      repeat (3) @(negedge Clk);
      checkOutput("rst_digitout", bus.DigitOut, 0);
      checkOutput("rst_valid", bus.DigitValid, 0);
      checkOutput("rst_accum", bus.Accum, 0);
      checkOutput("rst_count", bus.DigitCount, 0);
      checkOutput("rst_err", bus.Err, 0);
      Reset = 1'b0;
      @(negedge Clk);

      $display("[TB] single press of 5");
      pressDigit(5, 20);
      checkOutput("accum_5_const", bus.Accum, 32'h0005);

      clearAccum();
      checkOutput("clear_accum", bus.Accum, 0);
      checkOutput("clear_count", bus.DigitCount, 0);

      $display("[TB] digits 1..5 with saturation");
      p0 = pulseCount;
      for (int d = 1; d <= 5; d++)
         pressDigit(d, 10);
      checkOutput("seq_pulses", pulseCount - p0, 5);
      checkOutput("seq_accum_const", bus.Accum, 32'h2345);
      checkOutput("seq_count_const", bus.DigitCount, DIGITS);

      $display("[TB] randomized presses");
      clearAccum();
      for (int i = 0; i < 8; i++)
         pressDigit(int'($urandom_range(9, 0)), int'($urandom_range(15, 8)));

      $display("[TB] bouncing key 7");
      clearAccum();
      p0 = pulseCount;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'b1 << 7, 2);
         applyStimulus('0, 2);
      end
      checkOutput("bounce_no_pulse", pulseCount - p0, 0);
      pressDigit(7, 12);

      $display("[TB] multi-hot input");
      p0 = pulseCount;
      e0 = errCount;
      applyStimulus(10'b0000010010, 2);
      checkOutput("err_early", bus.Err, 0);
      applyStimulus(10'b0000010010, 1);
      checkOutput("err_edge3", bus.Err, 1);
      applyStimulus(10'b0000010010, 1);
`ifdef DECKEY_STICKY_ERR_EN
      checkOutput("err_sticky_hold", bus.Err, 1);
`else
      checkOutput("err_pulse_drop", bus.Err, 0);
`endif
      applyStimulus(10'b0000010010, 8);
`ifdef DECKEY_STICKY_ERR_EN
      checkOutput("err_sticky_long", bus.Err, 1);
`else
      checkOutput("err_pulse_count", errCount - e0, 1);
`endif
      checkOutput("err_no_valid", pulseCount - p0, 0);
      applyStimulus('0, 12);
      pressDigit(9, 12);
`ifdef DECKEY_STICKY_ERR_EN
      checkOutput("err_sticky_after_press", bus.Err, 1);
      clearAccum();
      checkOutput("err_sticky_cleared", bus.Err, 0);
`else
      checkOutput("err_pulse_idle", bus.Err, 0);
`endif

      $display("[TB] clear coincident with accept of 8");
      pressDigit(4, 10);
      bus.DECIn = 10'b1 << 8;
      repeat (5) @(negedge Clk);
      bus.Clear = 1'b1;
      @(negedge Clk);
      bus.Clear = 1'b0;
      modelClear();
      checkOutput("clr_acc_valid", bus.DigitValid, 1);
      checkOutput("clr_acc_digit", bus.DigitOut, 8);
      checkOutput("clr_acc_accum", bus.Accum, modelAccum());
      checkOutput("clr_acc_count", bus.DigitCount, modelCount());
      applyStimulus(10'b1 << 8, 4);
      applyStimulus('0, 12);

      $display("[TB] asynchronous reset mid-press");
      pressDigit(2, 10);
      bus.DECIn = 10'b1 << 3;
      repeat (4) @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("arst_digitout", bus.DigitOut, 0);
      checkOutput("arst_accum", bus.Accum, 0);
      checkOutput("arst_count", bus.DigitCount, 0);
      checkOutput("arst_err", bus.Err, 0);
      modelClear();
      p0 = pulseCount;
      bus.DECIn = '0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (12) @(negedge Clk);
      checkOutput("arst_no_pulse", pulseCount - p0, 0);
      pressDigit(6, 12);
      checkOutput("arst_accum6_const", bus.Accum, 32'h0006);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
